// File: rtl/cpu_bus_pkg.sv
// Shared types and address constants for the 6502 bus target.
package cpu_bus_pkg;

  // Region selected by one bus address; registered to steer DI a cycle later.
  typedef enum logic [2:0] {
    REG_RAM,
    REG_STATUS,
    REG_SW,
    REG_ROM,
    REG_NONE
  } region_e;

  localparam logic [15:0] STATUS_ADDR = 16'h1000;
  localparam logic [15:0] IO_ADDR     = 16'h1400;
  localparam logic [15:0] IRQACK_ADDR = 16'h1800;
  localparam logic [15:0] WDOG_ADDR   = 16'h1C00;
  localparam logic [15:0] ROM_BASE    = 16'h8000;

  typedef enum logic {
    WD_RUN,
    WD_PULSE
  } wd_state_e;

  // Exact decode: registers at 0x1xxx are single addresses, no mirrors.
  function automatic region_e decode_region(input logic [15:0] addr, input int ram_aw);
    region_e r;
    r = REG_NONE;
    if ((addr >> ram_aw) == 16'd0)  r = REG_RAM;
    else if (addr >= ROM_BASE)      r = REG_ROM;
    else if (addr == STATUS_ADDR)   r = REG_STATUS;
    else if (addr == IO_ADDR)       r = REG_SW;
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_target_if.sv
// CPU-side bus bundle: address, write data, write enable and read data.
interface cpu_bus_target_if;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;

  modport master (output AB, DO, WE, input DI);
  modport slave  (input AB, DO, WE, output DI);
endinterface

// File: rtl/bus_watchdog.sv
// Watchdog: counts cycles since the last kick and emits a fixed-length
// reset-request pulse when the limit is reached.
module bus_watchdog
  import cpu_bus_pkg::*;
#(
  parameter logic [19:0] WDOG_LIMIT = 20'd65536,
  parameter logic [4:0]  WDOG_PULSE = 5'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic warn,
  output logic rst_req
);

  wd_state_e   state_reg;
  logic [19:0] wd_cnt_reg;
  logic [4:0]  pulse_cnt_reg;
  logic        rst_req_reg;

  // FSM with registered request; kicks during the pulse are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= WD_RUN;
      wd_cnt_reg    <= 20'd0;
      pulse_cnt_reg <= 5'd0;
      rst_req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        WD_RUN: begin
          if (kick) begin
            wd_cnt_reg <= 20'd0;
          end else if (wd_cnt_reg == WDOG_LIMIT - 20'd1) begin
            state_reg     <= WD_PULSE;
            pulse_cnt_reg <= 5'd0;
            rst_req_reg   <= 1'b1;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 20'd1;
          end
        end
        WD_PULSE: begin
          if (pulse_cnt_reg == WDOG_PULSE - 5'd1) begin
            state_reg   <= WD_RUN;
            wd_cnt_reg  <= 20'd0;
            rst_req_reg <= 1'b0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 5'd1;
          end
        end
      endcase
    end
  end

  assign warn    = (wd_cnt_reg >= (WDOG_LIMIT >> 1));
  assign rst_req = rst_req_reg;

endmodule

// File: rtl/cpu_bus_target.sv
// Responder end of the 6502 bus: work RAM, ROM pass-through, switch/IO
// registers, periodic IRQ with acknowledge and a watchdog reset request.
module cpu_bus_target
  import cpu_bus_pkg::*;
#(
  parameter int          RAM_AW     = 10,
  parameter logic [15:0] IRQ_PERIOD = 16'd4096,
  parameter logic [19:0] WDOG_LIMIT = 20'd65536,
  parameter logic [4:0]  WDOG_PULSE = 5'd16
) (
  input  logic                clk,
  input  logic                rst,
  cpu_bus_target_if.slave     bus,
  output logic                IRQ,
  output logic                cpu_rst_req,
  output logic [14:0]         rom_addr,
  input  logic [7:0]          rom_data,
  input  logic [7:0]          sw_in,
  output logic [7:0]          io_out
);

  logic [7:0] ram_mem [0:(1<<RAM_AW)-1];
  logic [7:0] ram_q_reg;

  region_e    sel_next;
  region_e    sel_reg;
  logic       rd_valid_reg;
  logic [7:0] misc_reg;
  logic [7:0] di_hold_reg;
  logic [7:0] di_sel;
  logic [7:0] io_out_reg;

  logic [15:0] irq_cnt_reg;
  logic        irq_pending_reg;
  logic        irq_wrap;
  logic        irq_ack;
  logic        wd_kick;
  logic        wdog_warn;
  logic [7:0]  status;

  assign sel_next = decode_region(bus.AB, RAM_AW);
  assign irq_wrap = (irq_cnt_reg == IRQ_PERIOD - 16'd1);
  assign irq_ack  = bus.WE && (bus.AB == IRQACK_ADDR);
  assign wd_kick  = bus.WE && (bus.AB == WDOG_ADDR);
  assign status   = {6'b0, wdog_warn, irq_pending_reg};
  assign rom_addr = bus.AB[14:0];
  assign io_out   = io_out_reg;
  assign IRQ      = ~irq_pending_reg;

  // Work RAM with registered read; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.WE && sel_next == REG_RAM) ram_mem[bus.AB[RAM_AW-1:0]] <= bus.DO;
    ram_q_reg <= ram_mem[bus.AB[RAM_AW-1:0]];
  end

  // Register the region select, read-cycle flag, sampled STATUS/switches and io latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg      <= REG_NONE;
      rd_valid_reg <= 1'b0;
      misc_reg     <= 8'hFF;
      di_hold_reg  <= 8'hFF;
      io_out_reg   <= 8'h00;
    end else begin
      sel_reg      <= sel_next;
      rd_valid_reg <= ~bus.WE;
      misc_reg     <= (sel_next == REG_STATUS) ? status : sw_in;
      di_hold_reg  <= bus.DI;
      if (bus.WE && bus.AB == IO_ADDR) io_out_reg <= bus.DO;
    end
  end

  // Steer read data from the source chosen last cycle; ROM data arrives now.
  always_comb begin
    di_sel = 8'hFF;
    case (sel_reg)
      REG_RAM:    di_sel = ram_q_reg;
      REG_STATUS: di_sel = misc_reg;
      REG_SW:     di_sel = misc_reg;
      REG_ROM:    di_sel = rom_data;
      default:    di_sel = 8'hFF;
    endcase
  end

  // A write cycle does not disturb the last read value seen by the CPU.
  assign bus.DI = rd_valid_reg ? di_sel : di_hold_reg;

  // Periodic IRQ; a wrap in the same cycle as an ack keeps the request set.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_cnt_reg     <= 16'd0;
      irq_pending_reg <= 1'b0;
    end else begin
      irq_cnt_reg <= irq_wrap ? 16'd0 : irq_cnt_reg + 16'd1;
      if (irq_wrap)     irq_pending_reg <= 1'b1;
      else if (irq_ack) irq_pending_reg <= 1'b0;
    end
  end

  bus_watchdog #(
    .WDOG_LIMIT (WDOG_LIMIT),
    .WDOG_PULSE (WDOG_PULSE)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (wd_kick),
    .warn    (wdog_warn),
    .rst_req (cpu_rst_req)
  );

endmodule

// File: tb/tb_cpu_bus_target.sv
// Bench for cpu_bus_target: table of bus transactions checked through a
// scoreboard queue, plus hand sequences for IRQ, watchdog and reset.
module tb_cpu_bus_target;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        IRQ;
  logic        cpu_rst_req;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sw_in;
  logic [7:0]  io_out;

  cpu_bus_target_if bus();

  cpu_bus_target #(
    .RAM_AW     (10),
    .IRQ_PERIOD (16'd8),
    .WDOG_LIMIT (20'd32),
    .WDOG_PULSE (5'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .IRQ         (IRQ),
    .cpu_rst_req (cpu_rst_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sw_in       (sw_in),
    .io_out      (io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rom;
    logic [7:0]  sw;
    logic        chk;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  vec_t vecs[18];
  sb_t  exp_q[$];
  bit   chk_pending = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", nm, act);
    end
  endtask

  // One bus cycle: compare the previous read's DI, then drive the next access.
  task automatic step(input logic [15:0] a, input logic we_i, input logic [7:0] d,
                      input logic [7:0] rom, input logic [7:0] sw,
                      input logic chk, input logic [7:0] exp, input string nm);
    sb_t e;
    @(posedge clk); #1;
    if (chk_pending) begin
      e = exp_q.pop_front();
      check(e.name, {8'h00, bus.DI}, {8'h00, e.exp});
    end
    bus.AB = a; bus.WE = we_i; bus.DO = d;
    rom_data = rom; sw_in = sw;
    chk_pending = chk;
    if (chk) exp_q.push_back('{nm, exp});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; bus.WE = 1'b0; bus.AB = 16'h2000; bus.DO = 8'h00;
    chk_pending = 0; exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_di"},   {8'h00, bus.DI}, 16'h00FF);
    check({tag, "_irq"},  {15'd0, IRQ}, 16'd1);
    check({tag, "_req"},  {15'd0, cpu_rst_req}, 16'd0);
    check({tag, "_io"},   {8'h00, io_out}, 16'h0000);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    //          addr      we    wdata  rom    sw     chk   exp    name
    vecs[0]  = '{16'h0123, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 8'h00, ""};
    vecs[1]  = '{16'h0124, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h00, ""};
    vecs[2]  = '{16'h0123, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hA5, "ram_0123"};
    vecs[3]  = '{16'h0124, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h5A, "ram_0124"};
    vecs[4]  = '{16'h9ABC, 1'b0, 8'h00, 8'h3C, 8'h00, 1'b1, 8'h3C, "rom_9abc"};
    vecs[5]  = '{16'h02BC, 1'b1, 8'h33, 8'h3C, 8'h00, 1'b0, 8'h00, ""};
    vecs[6]  = '{16'h9ABC, 1'b1, 8'h11, 8'h3C, 8'h00, 1'b0, 8'h00, ""};
    vecs[7]  = '{16'h02BC, 1'b0, 8'h00, 8'h3C, 8'h00, 1'b1, 8'h33, "rom_wr_ignored"};
    vecs[8]  = '{16'h2000, 1'b0, 8'h00, 8'h3C, 8'h00, 1'b1, 8'hFF, "unmapped_2000"};
    vecs[9]  = '{16'h03FF, 1'b1, 8'hC3, 8'h3C, 8'h00, 1'b0, 8'h00, ""};
    vecs[10] = '{16'h03FF, 1'b0, 8'h00, 8'h3C, 8'h00, 1'b1, 8'hC3, "ram_top"};
    vecs[11] = '{16'h0400, 1'b0, 8'h00, 8'h3C, 8'h00, 1'b1, 8'hFF, "past_ram"};
    vecs[12] = '{16'h1400, 1'b0, 8'h00, 8'h3C, 8'h81, 1'b1, 8'h81, "sw_read"};
    vecs[13] = '{16'h1401, 1'b0, 8'h00, 8'h3C, 8'h81, 1'b1, 8'hFF, "no_mirror"};
    vecs[14] = '{16'h1800, 1'b0, 8'h00, 8'h3C, 8'h81, 1'b1, 8'hFF, "ack_read"};
    vecs[15] = '{16'h1C00, 1'b0, 8'h00, 8'h3C, 8'h81, 1'b1, 8'hFF, "kick_read"};
    vecs[16] = '{16'h0123, 1'b0, 8'h00, 8'h3C, 8'h81, 1'b1, 8'hA5, "ram_reread"};
    vecs[17] = '{16'h0200, 1'b1, 8'h00, 8'h3C, 8'h81, 1'b1, 8'hA5, "di_hold"};

    rom_data = 8'h00; sw_in = 8'h00;
    do_reset("reset");

    // Table-driven bus transactions.
    for (int i = 0; i < 18; i++)
      step(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].rom, vecs[i].sw,
           vecs[i].chk, vecs[i].exp, vecs[i].name);
    step(16'h9ABC, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "");
    #1 check("rom_addr", {1'b0, rom_addr}, 16'h1ABC);
    step(16'h2000, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "");

    // IRQ timer and unkicked watchdog from reset, with STATUS read each cycle.
    do_reset("rst_irq");
    bus.AB = STATUS_ADDR;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      check($sformatf("irq_k%0d", k), {15'd0, IRQ}, (k < 8) ? 16'd1 : 16'd0);
      check($sformatf("wd_req_k%0d", k), {15'd0, cpu_rst_req},
            (k >= 32 && k <= 35) ? 16'd1 : 16'd0);
      if (k <= 31)
        check($sformatf("status_k%0d", k), {8'h00, bus.DI},
              {14'd0, (k - 1) >= 16, (k - 1) >= 8});
    end
    bus.AB = IRQACK_ADDR; bus.WE = 1'b1;
    @(posedge clk); #1;
    check("irq_ack", {15'd0, IRQ}, 16'd1);
    bus.AB = 16'h2000; bus.WE = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("irq_before_wrap", {15'd0, IRQ}, 16'd1);
    bus.AB = IRQACK_ADDR; bus.WE = 1'b1;
    @(posedge clk); #1;
    check("ack_vs_wrap", {15'd0, IRQ}, 16'd0);
    bus.AB = 16'h2000; bus.WE = 1'b0;

    // Kicks every 20 cycles keep the request low.
    do_reset("rst_kick");
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      check($sformatf("wd_kicked_k%0d", k), {15'd0, cpu_rst_req}, 16'd0);
      bus.WE = (k % 20 == 0);
      bus.AB = (k % 20 == 0) ? WDOG_ADDR : 16'h2000;
    end
    bus.WE = 1'b0; bus.AB = 16'h2000;

    // Kick arriving exactly on the limit cycle prevents the pulse.
    do_reset("rst_limit");
    repeat (31) @(posedge clk);
    #1;
    bus.WE = 1'b1; bus.AB = WDOG_ADDR;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("wd_limit_kick_k%0d", k), {15'd0, cpu_rst_req}, 16'd0);
      bus.WE = 1'b0; bus.AB = 16'h2000;
    end

    // Reset in the middle of a pulse; RAM keeps its data.
    do_reset("rst_pre");
    step(16'h0010, 1'b1, 8'h6C, 8'h00, 8'h00, 1'b0, 8'h00, "");
    step(IO_ADDR,  1'b1, 8'h77, 8'h00, 8'h00, 1'b0, 8'h00, "");
    step(16'h2000, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "");
    check("io_out", {8'h00, io_out}, 16'h0077);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      found = cpu_rst_req;
    end
    check("wd_pulse_seen", {15'd0, found}, 16'd1);
    do_reset("rst_mid_pulse");
    step(16'h0010, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h6C, "ram_after_rst");
    step(16'h2000, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_bus_target.md
Name: cpu_bus_target

Overview:
- Slave/responder end of the main 6502 CPU bus.
- Decodes the CPU's address, write-enable and write-data outputs, then returns the read data the core samples on the next cycle.
- Owns 1 KB work RAM, a switch/IO register pair, a periodic IRQ generator with acknowledge, and a watchdog that requests CPU reset.
- Sits between the cpu instance and the external program ROM and IO.

Parameters:
- RAM_AW, 10, work RAM address width (2^RAM_AW bytes, mapped at 0x0000).
- IRQ_PERIOD, 16'd4096, clk cycles between IRQ assertions (must be >= 2).
- WDOG_LIMIT, 20'd65536, cycles without a kick before a reset request (must be >= 2).
- WDOG_PULSE, 5'd16, length in cycles of the reset-request pulse.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- AB  input  16  CPU address bus.
- DO  input  8  CPU write data.
- WE  input  1  CPU write enable, 1 = write.
- DI  output  8  read data to the CPU, registered.
- IRQ  output  1  interrupt to the CPU, active-low.
- cpu_rst_req  output  1  watchdog reset request, active-high.
- rom_addr  output  15  ROM address, combinational AB[14:0].
- rom_data  input  8  ROM data, valid one cycle after rom_addr.
- sw_in  input  8  switch inputs.
- io_out  output  8  output latch.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Address map; bus accesses decode every cycle, there are no wait states:
  - 0x0000–0x03FF: RAM, read/write.
  - 0x1000: read STATUS = {6'b0, wdog_warn, irq_pending}; writes ignored.
  - 0x1400: read sw_in; write loads io_out.
  - 0x1800: write = IRQ acknowledge; read returns 0xFF.
  - 0x1C00: write = watchdog kick; read returns 0xFF.
  - 0x8000–0xFFFF: ROM, read-only; writes ignored.
  - All other addresses: reads return 0xFF, writes ignored.
  - Decode is exact: the 0x1xxx registers do not mirror.
- Read latency is exactly 1 cycle:
  - Each cycle the region select of AB is registered.
  - On the next cycle DI is driven from the RAM read register, rom_data, sw_in/STATUS as sampled, or 0xFF.
  - DI holds between reads.
- RAM write occurs at the clock edge where WE=1 and AB is in RAM. A read of the same address on the next cycle returns the new data.
- IRQ timer:
  - irq_cnt counts 0 .. IRQ_PERIOD-1, then wraps.
  - At wrap, irq_pending is set.
  - An ack write clears irq_pending.
  - If wrap and ack occur in the same cycle, set wins.
  - IRQ = ~irq_pending.
- Watchdog FSM, states RUN and PULSE:
  - RUN: wd_cnt increments each cycle; a kick clears it to 0.
  - wdog_warn = (wd_cnt >= WDOG_LIMIT/2).
  - When wd_cnt reaches WDOG_LIMIT-1 without a kick, go to PULSE. cpu_rst_req=1 for exactly WDOG_PULSE cycles, then return to RUN with wd_cnt=0.
  - In PULSE, kicks are ignored. The IRQ timer and RAM contents are unaffected.
  - A kick in the same cycle as the limit is reached prevents PULSE.
- Reset values (on rst, in any state, mid-pulse included):
  - DI=0xFF, IRQ=1, irq_pending=0, irq_cnt=0.
  - cpu_rst_req=0, wd_cnt=0, FSM=RUN.
  - io_out=0x00, registered select = unmapped.
  - RAM contents are not reset.
- Width rules:
  - All counters are unsigned and sized from their parameters.
  - No counter saturates except through the wrap rules stated above.

Decomposition:
- Package cpu_bus_pkg:
  - Region enum: REG_RAM, REG_STATUS, REG_SW, REG_ROM, REG_NONE.
  - Address constants: STATUS_ADDR, IO_ADDR, IRQACK_ADDR, WDOG_ADDR, ROM_BASE.
  - Watchdog state typedef.
- Sub-module bus_watchdog: the watchdog FSM, its counter and the pulse. Interface is clk, rst, kick, warn, rst_req.
- RAM is an inferred synchronous array in the top module.

Test Plan:
- Write 0xA5 to 0x0123, then read 0x0123 → DI=0xA5 on the cycle after the read address. Read 0x0124 after writing 0x5A there → 0x5A.
- Read 0x9ABC with rom_data=0x3C → rom_addr=0x1ABC, DI=0x3C one cycle later. Write to 0x9ABC → no effect. Read 0x2000 → 0xFF.
- IRQ_PERIOD=8: IRQ falls after 8 cycles from reset. STATUS read → 0x01. Write 0x1800 → IRQ returns to 1 next cycle. Ack coincident with a wrap → IRQ stays 0.
- WDOG_LIMIT=32, WDOG_PULSE=4: no kicks → cpu_rst_req high for exactly 4 cycles starting at cycle 32, then low. With kicks every 20 cycles, it never asserts.
- Write 0x77 to 0x1400 → io_out=0x77. sw_in=0x81, read 0x1400 → DI=0x81.
- Assert rst during PULSE → cpu_rst_req=0, IRQ=1, io_out=0, DI=0xFF next cycle. RAM data written before the reset still reads back.
